// File: rtl/ifetch_pkg.sv
// Shared core definitions: datapath widths and the fetch FSM encoding.
// The decode stage imports this package as well.
package ifetch_pkg;

  localparam int INSTR_WIDTH = 32;
  localparam int ADDR_WIDTH  = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // no request, ir empty
    S_REQ  = 2'd1,  // read outstanding, waiting for imem_ack
    S_FULL = 2'd2   // ir holds an instruction, waiting for decode to consume
  } fetch_state_t;

endpackage

// File: rtl/ifetch_if.sv
// Fetch-stage bus: instruction memory read port plus the decode handshake.
// master = fetch stage, slave = memory/decode side.
interface ifetch_if #(
  parameter int INSTR_WIDTH = ifetch_pkg::INSTR_WIDTH,
  parameter int ADDR_WIDTH  = ifetch_pkg::ADDR_WIDTH
);
  logic                   imem_req;
  logic [ADDR_WIDTH-1:0]  imem_addr;
  logic [INSTR_WIDTH-1:0] imem_rdata;
  logic                   imem_ack;
  logic [INSTR_WIDTH-1:0] ir;
  logic                   ir_valid;
  logic                   ir_ready;
  logic [ADDR_WIDTH-1:0]  pc;
  logic                   br;
  logic [ADDR_WIDTH-1:0]  br_addr;

  modport master (
    output imem_req, imem_addr, ir, ir_valid, pc,
    input  imem_rdata, imem_ack, ir_ready, br, br_addr
  );

  modport slave (
    input  imem_req, imem_addr, ir, ir_valid, pc,
    output imem_rdata, imem_ack, ir_ready, br, br_addr
  );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch stage: one outstanding read at a time, a single
// instruction register towards decode, branch redirect on consume.
module ifetch #(
  parameter int                    INSTR_WIDTH = ifetch_pkg::INSTR_WIDTH,
  parameter int                    ADDR_WIDTH  = ifetch_pkg::ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     en,
  ifetch_if.master bus
);
  import ifetch_pkg::*;

  fetch_state_t           state;
  logic [ADDR_WIDTH-1:0]  fetch_pc;
  logic [ADDR_WIDTH-1:0]  fetch_pc_nxt;
  logic                   req_q;
  logic                   valid_q;
  logic [INSTR_WIDTH-1:0] ir_q;
  logic [ADDR_WIDTH-1:0]  pc_q;
  logic                   take;
  logic                   consume;

  // ack only counts while a read is outstanding; br only on a consume edge
  assign take    = (state == S_REQ)  && bus.imem_ack;
  assign consume = (state == S_FULL) && bus.ir_ready;

  // Next fetch address: increment after a read lands, branch target on a
  // consuming branch, otherwise hold. The two events live in different
  // states so they can never collide.
  always_comb begin
    fetch_pc_nxt = fetch_pc;
    if (take)                 fetch_pc_nxt = fetch_pc + ADDR_WIDTH'(1);
    else if (consume && bus.br) fetch_pc_nxt = bus.br_addr;
  end

  // Fetch FSM with registered request, instruction and pc outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      ir_q     <= '0;
      pc_q     <= '0;
    end else begin
      fetch_pc <= fetch_pc_nxt;
      unique case (state)
        S_IDLE: begin
          if (en) begin
            state <= S_REQ;
            req_q <= 1'b1;
          end
        end
        S_REQ: begin
          // en is deliberately ignored here: the read always completes
          if (bus.imem_ack) begin
            state   <= S_FULL;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
            ir_q    <= bus.imem_rdata;
            pc_q    <= fetch_pc;
          end
        end
        S_FULL: begin
          if (bus.ir_ready) begin
            valid_q <= 1'b0;
            req_q   <= en;
            state   <= en ? S_REQ : S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  // imem_addr follows fetch_pc, which only moves outside S_REQ or on the ack edge
  assign bus.imem_req  = req_q;
  assign bus.imem_addr = fetch_pc;
  assign bus.ir        = ir_q;
  assign bus.ir_valid  = valid_q;
  assign bus.pc        = pc_q;

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter INSTR_WIDTH, default 32: instruction word width.
REQ-002 Parameter ADDR_WIDTH, default 6: instruction address width.
REQ-003 Parameter RESET_PC, default 0: first fetch address after reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 en  input  1  fetch enable.
REQ-007 imem_req  output  1  instruction memory read request.
REQ-008 imem_addr  output  ADDR_WIDTH  read address.
REQ-009 imem_rdata  input  INSTR_WIDTH  read data, valid with imem_ack.
REQ-010 imem_ack  input  1  read complete.
REQ-011 ir  output  INSTR_WIDTH  fetched instruction to the decode stage.
REQ-012 ir_valid  output  1  ir holds an unconsumed instruction.
REQ-013 ir_ready  input  1  decode stage accepts ir.
REQ-014 pc  output  ADDR_WIDTH  address of the instruction in ir.
REQ-015 br  input  1  decode reports ir is a branch.
REQ-016 br_addr  input  ADDR_WIDTH  branch target from decode.

Function
REQ-017 The block SHALL implement a three-state FSM: IDLE (no request, ir empty), REQ (imem_req=1, waiting for ack), FULL (ir_valid=1, waiting for consume).
REQ-018 IDLE -> REQ when en=1; otherwise stay in IDLE.
REQ-019 In REQ, imem_req SHALL be 1 and imem_addr SHALL equal the internal fetch_pc, both stable until ack is sampled.
REQ-020 In REQ, when imem_ack=1 on a clock edge: ir<=imem_rdata, pc<=fetch_pc, fetch_pc<=fetch_pc+1 modulo 2^ADDR_WIDTH (63 wraps to 0), and state -> FULL.
REQ-021 Deasserting en while in REQ SHALL NOT drop imem_req; the outstanding read SHALL complete.
REQ-022 imem_ack SHALL be ignored when imem_req=0.
REQ-023 ir_valid SHALL be 1 exactly in FULL; ir and pc SHALL stay stable while ir_valid=1 and ir_ready=0.
REQ-024 Consume occurs on an edge where ir_valid=1 and ir_ready=1; then state -> REQ if en=1, otherwise IDLE.
REQ-025 br and br_addr SHALL be sampled only on a consume edge; otherwise they are ignored.
REQ-026 On a consume edge with br=1, fetch_pc SHALL be set to br_addr, overriding the sequential value.
REQ-027 Only one memory request SHALL be outstanding at a time, so a redirect never has an in-flight fetch to cancel.
REQ-028 Latency: ir_valid rises on the edge that samples imem_ack. With a zero-wait memory, the peak rate is one instruction per two cycles.
REQ-029 When ir_valid=0, ir and pc SHALL retain their last values.

Reset
REQ-030 While rst=1, the block SHALL asynchronously force: state=IDLE, fetch_pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, ir=0, pc=0, ir_valid=0.
REQ-031 Reset asserted mid-REQ SHALL abandon the read; an ack arriving after reset SHALL be ignored.
REQ-032 The first imem_req SHALL rise one cycle after the first edge with rst=0 and en=1.

Structure
REQ-033 INSTR_WIDTH, ADDR_WIDTH and the FSM state encoding SHALL live in the shared core package, which the decode stage also uses.
REQ-034 No sub-module is required. Next-PC selection (hold, increment or branch target) SHALL be a single mux inside ifetch.

Verification
REQ-035 Sequential fetch: memory with 0-wait ack, ir_ready=1, non-branch words at 0..3 -> pc sequence 0,1,2,3; ir_valid on alternate cycles; ir matches memory contents.
REQ-036 Backpressure: ir_ready=0 for 5 cycles with ir=0x40000001 at pc=2 -> ir, pc and ir_valid held, imem_req=0. On the first cycle ir_ready=1, consume, then fetch of address 3.
REQ-037 Branch: word at pc=4 is 0x0000002A, br=1, br_addr=42 on consume -> next imem_addr=42 and pc=42. A br=1 pulse with ir_ready=0 -> no redirect.
REQ-038 Wrap: start at fetch_pc=63 -> after fetching 63, next imem_addr=0.
REQ-039 Wait states plus en drop: ack delayed 3 cycles, en=0 in the cycle after req rises -> req held and addr stable until ack. After consume, the FSM goes to IDLE with no further req.
REQ-040 Reset mid-fetch: assert rst during REQ, then give a stale ack -> outputs at reset values, no ir_valid, next fetch at RESET_PC.
